// File: rtl/spi_sub_burst_if.sv
// SPI pins plus memory-side strobes of the SPI-to-memory bridge, bundled for one port.
interface spi_sub_burst_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              r_en;
  logic              w_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] data_i;
  logic              abort;

  modport slave (
    input  cs_n, mosi, data_i,
    output miso, r_en, w_en, addr, data_o, abort
  );

  modport master (
    output cs_n, mosi, data_i,
    input  miso, r_en, w_en, addr, data_o, abort
  );
endinterface

// File: rtl/spi_sub_burst.sv
// SPI subordinate: one {op, addr, data} frame in, one memory cycle, one response frame out.
// Op 10 keeps re-reading at addr+1 after each response until cs_n rises.
module spi_sub_burst #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic            sclk,
  input logic            rst,
  spi_sub_burst_if.slave bus
);
  localparam int MSG_W = 2 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(MSG_W + 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] TX_END  = CNT_W'(MSG_W);

  typedef enum logic [1:0] {IDLE, RX, MEM, TX} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MSG_W-1:0]  rx_q, rx_d;
  logic [MSG_W-1:0]  tx_q, tx_d;
  logic              mem_ph_q, mem_ph_d;
  logic              miso_q, miso_d;
  logic              r_en_q, r_en_d;
  logic              w_en_q, w_en_d;
  logic              abort_q, abort_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_o_q, data_o_d;
  logic [1:0]        op;
  logic [MSG_W-1:0]  resp;

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      mem_ph_q <= 1'b0;
      miso_q   <= 1'b0;
      r_en_q   <= 1'b0;
      w_en_q   <= 1'b0;
      abort_q  <= 1'b0;
      addr_q   <= '0;
      data_o_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      mem_ph_q <= mem_ph_d;
      miso_q   <= miso_d;
      r_en_q   <= r_en_d;
      w_en_q   <= w_en_d;
      abort_q  <= abort_d;
      addr_q   <= addr_d;
      data_o_q <= data_o_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    mem_ph_d = mem_ph_q;
    miso_d   = 1'b0;
    r_en_d   = 1'b0;
    w_en_d   = 1'b0;
    abort_d  = 1'b0;
    addr_d   = addr_q;
    data_o_d = data_o_q;
    op       = rx_q[MSG_W-1 -: 2];
    resp     = '0;

    if (bus.cs_n) begin
      state_d  = IDLE;
      cnt_d    = '0;
      mem_ph_d = 1'b0;
      abort_d  = (state_q != IDLE);
    end else begin
      unique case (state_q)
        IDLE: begin
          rx_d    = {rx_q[MSG_W-2:0], bus.mosi};
          cnt_d   = CNT_W'(1);
          state_d = RX;
        end
        RX: begin
          rx_d = {rx_q[MSG_W-2:0], bus.mosi};
          if (cnt_q == RX_LAST) begin
            cnt_d    = '0;
            mem_ph_d = 1'b0;
            state_d  = MEM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Phase 0 raises the strobe; phase 1 drops it and samples data_i into the response.
        MEM: begin
          if (!mem_ph_q) begin
            mem_ph_d = 1'b1;
            addr_d   = rx_q[DATA_W +: ADDR_W];
            unique case (op)
              2'b00, 2'b10: r_en_d = 1'b1;
              2'b01: begin
                w_en_d   = 1'b1;
                data_o_d = rx_q[DATA_W-1:0];
              end
              default: ;
            endcase
          end else begin
            unique case (op)
              2'b00, 2'b10: resp = {op, addr_q, bus.data_i};
              2'b01:        resp = rx_q;
              default:      resp = '1;
            endcase
            mem_ph_d = 1'b0;
            miso_d   = resp[MSG_W-1];
            tx_d     = {resp[MSG_W-2:0], 1'b0};
            cnt_d    = CNT_W'(1);
            state_d  = TX;
          end
        end
        TX: begin
          if (cnt_q == TX_END) begin
            cnt_d = '0;
            if (op == 2'b10) begin
              addr_d   = addr_q + ADDR_W'(1);
              r_en_d   = 1'b1;
              mem_ph_d = 1'b1;
              state_d  = MEM;
            end else begin
              state_d = RX;
            end
          end else begin
            miso_d = tx_q[MSG_W-1];
            tx_d   = {tx_q[MSG_W-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.miso   = miso_q;
  assign bus.r_en   = r_en_q;
  assign bus.w_en   = w_en_q;
  assign bus.abort  = abort_q;
  assign bus.addr   = addr_q;
  assign bus.data_o = data_o_q;
endmodule
